ieee_to_flopoco_7_7: RTL and testbench
======================================

Name: ieee_to_flopoco_7_7

Overview:
- Pipelined input converter from a 15-bit IEEE-style float (1 sign, 7 exponent bits with bias 63, 7 fraction bits) to the 17-bit FloPoCo (7,7) format consumed by fcmplt and the other FloPoCo cores.
- Sits at the boundary between the memory/stream side and the FloPoCo datapath. It is the producer end of the FloPoCo encoding that fcmplt decodes.
- Valid/ready streaming, 2-stage pipeline with full backpressure, saturating event counters for flushed subnormals and NaNs.

Parameters:
- ID, 1, instance identifier (no functional effect; matches FloPoCo core convention)
- CNT_W, 16, width of the event counters

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  converter accepts in_data this cycle
- in_data  input  15  IEEE word: [14] sign, [13:7] exponent, [6:0] fraction
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  17  FloPoCo word: [16:15] exc, [14] sign, [13:7] exponent, [6:0] fraction
- cnt_clear  input  1  synchronous clear of both counters
- flush_cnt  output  CNT_W  subnormals flushed to zero (saturating)
- nan_cnt  output  CNT_W  NaN inputs seen (saturating)

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, flush_cnt=0, nan_cnt=0. in_ready=1 from the first cycle after reset release.
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- out_valid and out_data must stay stable while out_valid & !out_ready.
- Stage 1 registers the raw word plus the class: zero, subnormal, normal, inf, nan.
- Stage 2 registers the packed out_data. out_valid = s2_valid.
- Advance condition: s2 loads when !s2_valid | out_ready. s1 loads when !s1_valid | s2 loads.
- in_ready = !s1_valid | s2 loads, computed combinationally from pipeline state and out_ready. No combinational path from in_valid to in_ready.
- Latency: 2 cycles from input transfer to out_valid when out_ready=1. Throughput 1 word/cycle. No bubbles and no drops under any out_ready pattern.
- Classification, applied to the input word (e = exponent field, f = fraction field, sign preserved in every case):
  - e=0, f=0: exc=00, exp=0, frac=0.
  - e=0, f!=0: subnormal. Flushed to exc=00 with exp=0, frac=0; flush_cnt increments.
  - e=127, f=0: exc=10, exp=0, frac=0.
  - e=127, f!=0: exc=11, exp=0, frac=0; nan_cnt increments.
  - otherwise: exc=01, exp=e, frac=f copied unchanged.
- Counters:
  - Increment on the cycle the classified word moves from s1 to s2, so each word is counted exactly once even under stalls.
  - Both saturate at 2^CNT_W-1.
  - cnt_clear has priority over a same-cycle increment: result is 0.
- Simultaneous full pipeline with out_ready=1 and in_valid=1: input accepted, s1 moves to s2, s2 drains, all in one cycle.
- Reset mid-stream: in-flight words are discarded and counters zeroed. No output is produced for pre-reset inputs.

Test Plan:
- 1.0 (in_data=0x1F80), out_ready=1 -> out_data=0x09F80 two cycles after acceptance; counters unchanged.
- -inf (0x7F80) -> 0x14000. NaN (0x3FC0) -> 0x18000 with nan_cnt=1. -0 (0x4000) -> 0x04000.
- Subnormal 0x0001 -> 0x00000, flush_cnt=1. Same input held 5 cycles under stall, then drained -> flush_cnt still 1.
- Back-to-back stream of 8 words with out_ready toggling 1,0,0,1,... -> all 8 outputs emitted in order, no loss or duplication, out_data stable during every stall.
- Counter saturation with CNT_W=2: 5 NaN inputs -> nan_cnt=3. cnt_clear asserted together with a NaN transfer -> nan_cnt=0.
- Assert rst with 2 words in flight -> out_valid=0 immediately (asynchronously), counters=0, in_ready=1 after release, neither in-flight word ever appears at the output.

Source files
------------

// File: rtl/ieee_to_flopoco_7_7.sv
// ieee_to_flopoco_7_7
//   Converts a 15-bit IEEE-style float (sign, 7-bit exponent with bias 63,
//   7-bit fraction) into the 17-bit FloPoCo (7,7) word used by the FloPoCo
//   cores. The FloPoCo exception field is {00 zero, 01 normal, 10 inf, 11 nan}.
//   Subnormal inputs are flushed to signed zero.
//   Two-stage valid/ready pipeline with full backpressure:
//     stage 1 holds the raw fields plus their class,
//     stage 2 holds the packed FloPoCo word (drives out_data).
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake, in_data = {sign, exp[6:0], frac[6:0]}
//   out_valid/out_ready  output handshake, out_data = {exc[1:0], sign, exp, frac}
//   cnt_clear            synchronous clear of both event counters
//   flush_cnt            saturating count of subnormals flushed to zero
//   nan_cnt              saturating count of NaN inputs
module ieee_to_flopoco_7_7 #(
  parameter int ID    = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16:0]      out_data,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] nan_cnt
);

  typedef enum logic [2:0] {
    CL_ZERO,
    CL_SUB,
    CL_NORM,
    CL_INF,
    CL_NAN
  } class_t;

  // ID only tags the instance; it has no functional effect.
  logic unused_id;
  assign unused_id = (ID != 0);

  logic       in_sign;
  logic [6:0] in_exp;
  logic [6:0] in_frac;
  class_t     in_class;

  logic       s1_valid;
  logic       s1_sign;
  logic [6:0] s1_exp;
  logic [6:0] s1_frac;
  class_t     s1_class;

  logic       s2_valid;

  logic       s1_load;
  logic       s2_load;
  logic       s1_move;

  logic [1:0] pack_exc;
  logic [6:0] pack_exp;
  logic [6:0] pack_frac;

  assign in_sign = in_data[14];
  assign in_exp  = in_data[13:7];
  assign in_frac = in_data[6:0];

  always_comb begin
    in_class = CL_NORM;
    if (in_exp == 7'd0) begin
      in_class = (in_frac == 7'd0) ? CL_ZERO : CL_SUB;
    end else if (in_exp == 7'h7f) begin
      in_class = (in_frac == 7'd0) ? CL_INF : CL_NAN;
    end
  end

  // Stage 2 frees up when empty or draining; stage 1 frees up when empty or
  // when its word moves on. in_ready depends only on state and out_ready.
  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_valid = s2_valid;

  // A word is counted exactly once: on the cycle it leaves stage 1.
  assign s1_move = s1_valid && s2_load;

  always_comb begin
    pack_exc  = 2'b01;
    pack_exp  = s1_exp;
    pack_frac = s1_frac;
    case (s1_class)
      CL_ZERO, CL_SUB: begin
        pack_exc  = 2'b00;
        pack_exp  = 7'd0;
        pack_frac = 7'd0;
      end
      CL_INF: begin
        pack_exc  = 2'b10;
        pack_exp  = 7'd0;
        pack_frac = 7'd0;
      end
      CL_NAN: begin
        pack_exc  = 2'b11;
        pack_exp  = 7'd0;
        pack_frac = 7'd0;
      end
      default: begin
        pack_exc  = 2'b01;
        pack_exp  = s1_exp;
        pack_frac = s1_frac;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= 7'd0;
      s1_frac  <= 7'd0;
      s1_class <= CL_ZERO;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_exp   <= in_exp;
        s1_frac  <= in_frac;
        s1_class <= in_class;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= 17'd0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= {pack_exc, s1_sign, pack_exp, pack_frac};
      end
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
      nan_cnt   <= '0;
    end else if (cnt_clear) begin
      flush_cnt <= '0;
      nan_cnt   <= '0;
    end else if (s1_move) begin
      if (s1_class == CL_SUB && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (s1_class == CL_NAN && nan_cnt != '1) begin
        nan_cnt <= nan_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ieee_to_flopoco_7_7.sv
module tb_ieee_to_flopoco_7_7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [14:0] in_data;
  logic        out_ready;
  logic        cnt_clear;

  logic        in_ready, out_valid;
  logic [16:0] out_data;
  logic [15:0] flush_cnt, nan_cnt;

  logic        in_ready2, out_valid2;
  logic [16:0] out_data2;
  logic [1:0]  flush_cnt2, nan_cnt2;

  int tests = 0;
  int fails = 0;

  logic [16:0] q[$];
  int  ex_flush = 0;
  int  ex_nan   = 0;
  int  occ;
  logic [16:0] exp_word;
  bit  mon_on = 0;
  bit  prev_stall = 0;
  logic [16:0] prev_data;
  int  mode = 0;
  int  pat = 0;

  always #5 clk = ~clk;

  ieee_to_flopoco_7_7 #(.ID(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clear(cnt_clear), .flush_cnt(flush_cnt), .nan_cnt(nan_cnt)
  );

  ieee_to_flopoco_7_7 #(.ID(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .cnt_clear(cnt_clear), .flush_cnt(flush_cnt2), .nan_cnt(nan_cnt2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference conversion written directly from the format rules.
  function automatic logic [16:0] conv(input logic [14:0] w);
    logic       s;
    logic [6:0] e, f;
    s = w[14]; e = w[13:7]; f = w[6:0];
    if (e == 7'd0)   return {2'b00, s, 14'd0};
    if (e == 7'h7f)  return {(f == 7'd0) ? 2'b10 : 2'b11, s, 14'd0};
    return {2'b01, s, e, f};
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  // Output ready generator: 0 always ready, 1 pattern 1,0,0, 2 random, 3 stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (pat == 0); pat = (pat + 1) % 3; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: handshakes are evaluated at the negedge, when all inputs
  // and outputs are settled for the upcoming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 0;
    end else if (mon_on) begin
      occ = q.size();
      check("in_ready_rule", in_ready, (occ < 2) || out_ready);
      if (occ != 1) check("out_valid_occupancy", out_valid, occ != 0);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        exp_word = q.pop_front();
        check("out_data", out_data, exp_word);
        check("out_data_w2", out_data2, exp_word);
      end
      if (in_valid && in_ready) begin
        q.push_back(conv(in_data));
        if (in_data[13:7] == 7'd0  && in_data[6:0] != 7'd0) ex_flush++;
        if (in_data[13:7] == 7'h7f && in_data[6:0] != 7'd0) ex_nan++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_mode(input int m);
    mode = m;
    step();
    step();
  endtask

  task automatic push(input logic [14:0] d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_remaining", q.size(), 0);
    step();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_flush"},  flush_cnt,  ex_flush[15:0]);
    check({tag, "_nan"},    nan_cnt,    ex_nan[15:0]);
    check({tag, "_flush2"}, flush_cnt2, sat3(ex_flush));
    check({tag, "_nan2"},   nan_cnt2,   sat3(ex_nan));
  endtask

  task automatic single(input string name, input logic [14:0] d, input logic [16:0] lit);
    push(d);
    @(negedge clk);
    check({name, "_lat1_valid"}, out_valid, 1'b0);
    @(negedge clk);
    check({name, "_lat2_valid"}, out_valid, 1'b1);
    check({name, "_value"}, out_data, lit);
    step();
  endtask

  function automatic logic [14:0] rand_word();
    logic [14:0] w;
    int k;
    w = 15'($urandom);
    k = $urandom_range(0, 5);
    case (k)
      0: w[13:0] = 14'd0;
      1: begin w[13:7] = 7'd0;  if (w[6:0] == 7'd0) w[0] = 1'b1; end
      2: begin w[13:7] = 7'h7f; w[6:0] = 7'd0; end
      3: begin w[13:7] = 7'h7f; if (w[6:0] == 7'd0) w[3] = 1'b1; end
      default: w[13:7] = 7'($urandom_range(1, 126));
    endcase
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 15'd0;
    cnt_clear = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 17'd0);
    check("rst_flush", flush_cnt, 16'd0);
    check("rst_nan", nan_cnt, 16'd0);
    #11;
    rst = 1'b0;
    mon_on = 1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    step();

    // Directed conversions with fixed expected words.
    set_mode(0);
    single("one",     15'h1F80, 17'h09F80);
    check_counts("after_one");
    check("one_counts_untouched", flush_cnt + nan_cnt, 32'd0);
    single("neg_inf", 15'h7F80, 17'h14000);
    single("nan",     15'h3FC0, 17'h18000);
    check("nan_cnt_one", nan_cnt, 16'd1);
    single("neg_zero", 15'h4000, 17'h04000);
    single("normal_frac", 15'h2A55, 17'h0AA55);
    check_counts("after_directed");

    // Subnormal parked behind a stalled output.
    set_mode(3);
    push(15'h0001);
    repeat (5) step();
    check("flush_during_stall", flush_cnt, 16'd1);
    check("stalled_valid", out_valid, 1'b1);
    set_mode(0);
    drain();
    check("flush_after_drain", flush_cnt, 16'd1);
    check_counts("after_sub");

    // Back-to-back stream under a 1,0,0 ready pattern.
    pat = 0;
    set_mode(1);
    for (int i = 0; i < 8; i++) push(rand_word());
    drain();
    check_counts("after_stream");

    // Saturation on the narrow-counter instance.
    set_mode(0);
    for (int i = 0; i < 5; i++) push(15'h3FC1 + 15'(i));
    drain();
    check("nan2_saturated", nan_cnt2, 2'd3);
    check_counts("after_sat");

    // Clear in the same cycle the NaN is counted.
    push(15'h3FFF);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    ex_nan = 0;
    ex_flush = 0;
    drain();
    check("clear_vs_inc_nan", nan_cnt, 16'd0);
    check("clear_vs_inc_nan2", nan_cnt2, 2'd0);
    check_counts("after_clear");

    // Randomized traffic with random backpressure.
    set_mode(2);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      push(rand_word());
    end
    set_mode(0);
    drain();
    check_counts("after_random");

    // Reset with two words in flight.
    set_mode(3);
    push(15'h0005);
    push(15'h3FC2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 17'd0);
    check("midrst_flush", flush_cnt, 16'd0);
    check("midrst_nan", nan_cnt, 16'd0);
    ex_flush = 0;
    ex_nan = 0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    mode = 0;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_output", out_valid, 1'b0);
    end
    step();
    check_counts("after_midrst");
    single("post_rst_word", 15'h1F81, 17'h09F81);
    check_counts("final");

    mon_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "timeout");
  end

endmodule
